// File: rtl/shift_arbiter.sv
// Round-robin arbiter that shares one dual-channel right shifter among four requesters.
// Operands are latched at grant; results return on shared registers with a per-requester Ack pulse.
module shift_arbiter #(
  parameter int BW      = 15,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ*BW-1:0]   In1Bus,
  input  logic [NREQ*BW-1:0]   In2Bus,
  input  logic [NREQ*4-1:0]    AmtBus,
  output logic [NREQ-1:0]      Gnt,
  output logic [NREQ-1:0]      Ack,
  output logic [BW-1:0]        Out1,
  output logic [BW-1:0]        Out2,
  output logic                 Err,
  output logic                 SH_Start,
  output logic [BW-1:0]        SH_IN1,
  output logic [BW-1:0]        SH_IN2,
  output logic [4:0]           SH_Amount,
  input  logic [BW-1:0]        SH_OUT1,
  input  logic [BW-1:0]        SH_OUT2,
  input  logic                 SH_End,
  input  logic                 SH_Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  ptr;
  logic [7:0]  wd_cnt;
  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic        grant_fire;
  logic        end_fire;
  logic        timeout_fire;

  // Search order is ptr+1, ptr+2, ptr+3, ptr; walking it backwards lets the
  // highest-priority candidate overwrite the others.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] p);
    logic [1:0] idx;
    logic [2:0] r;
    r = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    {pick_valid, pick_idx} = rr_pick(Req, ptr);
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_fire)              state_next = WAIT;
      WAIT:    if (end_fire || timeout_fire) state_next = DONE;
      DONE:                                  state_next = IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  // Control strobes decoded from state; a stray End outside WAIT is ignored here.
  always_comb begin
    grant_fire   = (state == IDLE) && pick_valid;
    end_fire     = (state == WAIT) && SH_End;
    timeout_fire = (state == WAIT) && !SH_End && (wd_cnt == 8'(TIMEOUT - 1));
  end

  // Datapath and registered outputs.
  // NOTE: every register here, including the operand and result registers, is
  // reset so that all outputs read zero straight out of reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Gnt       <= '0;
      Ack       <= '0;
      Out1      <= '0;
      Out2      <= '0;
      Err       <= 1'b0;
      SH_Start  <= 1'b0;
      SH_IN1    <= '0;
      SH_IN2    <= '0;
      SH_Amount <= '0;
      ptr       <= 2'd3;
      wd_cnt    <= '0;
    end else begin
      SH_Start <= grant_fire;
      Ack      <= '0;

      if (grant_fire) begin
        Gnt       <= NREQ'(1) << pick_idx;
        SH_IN1    <= In1Bus[int'(pick_idx)*BW +: BW];
        SH_IN2    <= In2Bus[int'(pick_idx)*BW +: BW];
        SH_Amount <= {1'b0, AmtBus[int'(pick_idx)*4 +: 4]};
        wd_cnt    <= '0;
        ptr       <= pick_idx;
      end

      if (state == WAIT) wd_cnt <= wd_cnt + 8'd1;

      if (end_fire) begin
        Out1 <= SH_OUT1;
        Out2 <= SH_OUT2;
        Ack  <= Gnt;
        Gnt  <= '0;
      end

      // Abort keeps the previous results; Err is sticky until Reset.
      if (timeout_fire) begin
        Err <= 1'b1;
        Ack <= Gnt;
        Gnt <= '0;
      end
    end
  end

  // Shifter Busy is only monitored: it must be high for the whole WAIT after Start.
  a_busy_in_wait: assert property (@(posedge Clock) disable iff (Reset)
    (state == WAIT && !SH_Start) |-> SH_Busy);

  a_gnt_onehot: assert property (@(posedge Clock) disable iff (Reset)
    $onehot0(Gnt));

  a_start_pulse: assert property (@(posedge Clock) disable iff (Reset)
    SH_Start |=> !SH_Start);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural right-shifter model
// that can also be made to withhold End or inject a stray End.
module tb_shift_arbiter;

  localparam int BW      = 15;
  localparam int TIMEOUT = 63;

  logic              Clock = 1'b0;
  logic              Reset;
  logic [3:0]        Req;
  logic [4*BW-1:0]   In1Bus;
  logic [4*BW-1:0]   In2Bus;
  logic [15:0]       AmtBus;
  logic [3:0]        Gnt;
  logic [3:0]        Ack;
  logic [BW-1:0]     Out1;
  logic [BW-1:0]     Out2;
  logic              Err;
  logic              SH_Start;
  logic [BW-1:0]     SH_IN1;
  logic [BW-1:0]     SH_IN2;
  logic [4:0]        SH_Amount;
  logic [BW-1:0]     SH_OUT1;
  logic [BW-1:0]     SH_OUT2;
  logic              SH_End;
  logic              SH_Busy;

  logic              m_end;
  logic              m_busy;
  logic [3:0]        m_cnt;
  logic [BW-1:0]     m_o1;
  logic [BW-1:0]     m_o2;
  logic              sh_dead;
  logic              inject;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   t0;
  logic [3:0] a;
  logic gnt_ok;
  logic busy_ok;

  shift_arbiter #(.BW(BW), .NREQ(4), .TIMEOUT(TIMEOUT)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Req       (Req),
    .In1Bus    (In1Bus),
    .In2Bus    (In2Bus),
    .AmtBus    (AmtBus),
    .Gnt       (Gnt),
    .Ack       (Ack),
    .Out1      (Out1),
    .Out2      (Out2),
    .Err       (Err),
    .SH_Start  (SH_Start),
    .SH_IN1    (SH_IN1),
    .SH_IN2    (SH_IN2),
    .SH_Amount (SH_Amount),
    .SH_OUT1   (SH_OUT1),
    .SH_OUT2   (SH_OUT2),
    .SH_End    (SH_End),
    .SH_Busy   (SH_Busy)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  assign SH_End  = m_end | inject;
  assign SH_OUT1 = inject ? 15'h2AAA : m_o1;
  assign SH_OUT2 = inject ? 15'h1555 : m_o2;
  assign SH_Busy = m_busy;

  // Shifter model: Start sampled at t0+1, End pulses after edge t0+A+2.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_end  <= 1'b0;
      m_busy <= 1'b0;
      m_cnt  <= '0;
      m_o1   <= '0;
      m_o2   <= '0;
    end else begin
      m_end <= 1'b0;
      if (SH_Start) begin
        m_busy <= 1'b1;
        m_cnt  <= SH_Amount[3:0];
      end else if (sh_dead) begin
        if (Ack != 4'b0) m_busy <= 1'b0;
      end else if (m_busy) begin
        if (m_end) m_busy <= 1'b0;
        else if (m_cnt == 4'd0) begin
          m_end <= 1'b1;
          m_o1  <= SH_IN1 >> SH_Amount;
          m_o2  <= SH_IN2 >> SH_Amount;
        end else m_cnt <= m_cnt - 4'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [BW-1:0] x1, input logic [BW-1:0] x2,
                         input logic [3:0] amt);
    In1Bus[i*BW +: BW] = x1;
    In2Bus[i*BW +: BW] = x2;
    AmtBus[i*4 +: 4]   = amt;
  endtask

  // Steps until an Ack pulse, tracking Gnt one-hotness and Busy during WAIT.
  task automatic wait_ack(input int budget, output logic [3:0] seen);
    seen = 4'b0;
    for (int n = 0; n < budget; n++) begin
      step();
      gnt_ok = gnt_ok & $onehot0(Gnt);
      if (Gnt != 4'b0 && !SH_Start) busy_ok = busy_ok & SH_Busy;
      if (Ack != 4'b0) begin
        seen = Ack;
        break;
      end
    end
    check("ack_wait", {31'b0, |seen}, 32'd1);
  endtask

  int          order[10] = '{0, 1, 2, 3, 0, 2, 1, 3, 1, 3};
  logic [14:0] e1[4]     = '{15'h3800, 15'h1800, 15'h0888, 15'h1234};
  logic [14:0] e2[4]     = '{15'h0787, 15'h003C, 15'h0FFF, 15'h0001};

  initial begin
    Reset = 1'b1; Req = 4'b0; In1Bus = '0; In2Bus = '0; AmtBus = '0;
    sh_dead = 1'b0; inject = 1'b0; gnt_ok = 1'b1; busy_ok = 1'b1;
    repeat (3) step();
    check("rst_gnt",   Gnt, 0);
    check("rst_ack",   Ack, 0);
    check("rst_out1",  Out1, 0);
    check("rst_out2",  Out2, 0);
    check("rst_err",   Err, 0);
    check("rst_start", SH_Start, 0);
    check("rst_in1",   SH_IN1, 0);
    check("rst_amt",   SH_Amount, 0);
    Reset = 1'b0;
    step();
    check("idle_gnt", Gnt, 0);

    // Single request, amount 4; operand changed after latching.
    set_ops(0, 15'h7FFF, 15'h1234, 4'd4);
    Req = 4'b0001;
    step(); t0 = cyc;
    check("single_gnt",   Gnt, 4'b0001);
    check("single_start", SH_Start, 1);
    check("single_in1",   SH_IN1, 15'h7FFF);
    check("single_amt",   SH_Amount, 5'd4);
    In1Bus[0 +: BW] = 15'h0000;
    step();
    check("start_pulse", SH_Start, 0);
    check("in1_hold",    SH_IN1, 15'h7FFF);
    wait_ack(40, a);
    check("single_ack",  a, 4'b0001);
    check("single_lat",  cyc - t0, 7);
    check("single_out1", Out1, 15'h07FF);
    check("single_out2", Out2, 15'h0123);
    check("single_gnt0", Gnt, 0);
    Req = 4'b0;
    step();
    check("ack_pulse", Ack, 0);
    step();
    check("no_regrant", Gnt, 0);

    // Amount 0.
    set_ops(1, 15'h5555, 15'h7ABC, 4'd0);
    Req = 4'b0010;
    step(); t0 = cyc;
    wait_ack(40, a);
    check("amt0_ack",  a, 4'b0010);
    check("amt0_lat",  cyc - t0, 3);
    check("amt0_out1", Out1, 15'h5555);
    check("amt0_out2", Out2, 15'h7ABC);
    Req = 4'b0;
    repeat (2) step();

    // Amount 15, with Req dropped before Ack.
    set_ops(1, 15'h7FFF, 15'h4000, 4'd15);
    Req = 4'b0010;
    step(); t0 = cyc;
    check("amt15_amt", SH_Amount, 5'h0F);
    repeat (2) step();
    Req = 4'b0;
    wait_ack(40, a);
    check("amt15_ack",  a, 4'b0010);
    check("amt15_lat",  cyc - t0, 18);
    check("amt15_out1", Out1, 15'h0000);
    check("amt15_out2", Out2, 15'h0000);
    repeat (2) step();

    // Stray End while idle.
    inject = 1'b1;
    step();
    inject = 1'b0;
    check("stray_ack",  Ack, 0);
    check("stray_out1", Out1, 15'h0000);
    step();
    check("stray_gnt",  Gnt, 0);

    // Contention from reset, then re-request of 0 and 2.
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, 15'h0, 15'h0, 4'd0);
    set_ops(0, 15'h7000, 15'h0F0F, 4'd1);
    set_ops(1, 15'h6000, 15'h00F0, 4'd2);
    set_ops(2, 15'h4444, 15'h7FFF, 4'd3);
    set_ops(3, 15'h1234, 15'h0001, 4'd0);
    Req = 4'b1111;
    step();
    Reset = 1'b0;
    gnt_ok = 1'b1; busy_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) Req = 4'b0101;
      wait_ack(60, a);
      check($sformatf("rr_ack%0d", k),  a, 32'd1 << order[k]);
      check($sformatf("rr_out1_%0d", k), Out1, e1[order[k]]);
      check($sformatf("rr_out2_%0d", k), Out2, e2[order[k]]);
      Req = Req & ~a;
    end
    check("rr_onehot", gnt_ok, 1);
    repeat (2) step();

    // Move the pointer to 0, then 1 and 3 held: grants alternate 1,3,1,3.
    Req = 4'b0001;
    wait_ack(40, a);
    check("prep_ack", a, 4'b0001);
    Req = 4'b0;
    repeat (2) step();
    Req = 4'b1010;
    for (int k = 6; k < 10; k++) begin
      wait_ack(60, a);
      check($sformatf("fair_ack%0d", k - 6), a, 32'd1 << order[k]);
      if (k == 9) Req = 4'b0;
    end
    check("fair_onehot", gnt_ok, 1);
    check("busy_wait",   busy_ok, 1);
    repeat (2) step();

    // Shifter never ends: abort at TIMEOUT, Err sticky, next request still served.
    sh_dead = 1'b1;
    Req = 4'b0100;
    step(); t0 = cyc;
    wait_ack(100, a);
    check("to_ack",  a, 4'b0100);
    check("to_lat",  cyc - t0, TIMEOUT);
    check("to_err",  Err, 1);
    check("to_out1", Out1, 15'h1234);
    Req = 4'b0;
    sh_dead = 1'b0;
    repeat (2) step();
    check("to_err_sticky", Err, 1);
    Req = 4'b0100;
    step(); t0 = cyc;
    wait_ack(40, a);
    check("post_to_ack",  a, 4'b0100);
    check("post_to_lat",  cyc - t0, 6);
    check("post_to_out1", Out1, 15'h0888);
    check("post_to_err",  Err, 1);
    Req = 4'b0;
    repeat (2) step();

    // Reset three cycles into WAIT; pointer must return to 3.
    Req = 4'b0001;
    step();
    repeat (3) step();
    Reset = 1'b1;
    #1;
    check("mid_rst_gnt",   Gnt, 0);
    check("mid_rst_start", SH_Start, 0);
    check("mid_rst_in1",   SH_IN1, 0);
    check("mid_rst_amt",   SH_Amount, 0);
    check("mid_rst_err",   Err, 0);
    check("mid_rst_out1",  Out1, 0);
    Req = 4'b0101;
    step();
    Reset = 1'b0;
    wait_ack(40, a);
    check("after_rst_first", a, 4'b0001);
    Req = 4'b0100;
    wait_ack(40, a);
    check("after_rst_second", a, 4'b0100);
    Req = 4'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
